vdp_super_line_replay: RTL
==========================

VDP_SUPER_LINE_REPLAY -- requirements
Module: vdp_super_line_replay

Interface
REQ-001 Parameter MAX_PIXELS, default 720: line buffer depth in pixels.
REQ-002 clk  in  1  pixel clock.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 vdp_super  in  1  super mode enable; low acts as a synchronous clear.
REQ-005 line_start  in  1  one-cycle pulse, first cycle of each scanline.
REQ-006 frame_start  in  1  one-cycle pulse, first scanline of the frame; coincides with line_start.
REQ-007 active_line  in  1  sampled at line_start: line is fetched from VRAM (capture) rather than repeated.
REQ-008 pix_strobe  in  1  a pixel is present on pix_rgb this cycle.
REQ-009 pix_rgb  in  24  {red, green, blue}, 8 bits each, from the super-res pixel fetcher.
REQ-010 out_rgb  out  24  pixel sent to the video encoder.
REQ-011 out_strobe  out  1  out_rgb is valid.
REQ-012 replaying  out  1  high while the current line is served from the buffer.

Function
REQ-013 States are IDLE, CAPTURE and REPLAY; the state is evaluated only on line_start.
REQ-014 On line_start the state shall become: IDLE if vdp_super=0; CAPTURE if active_line=1; REPLAY if active_line=0 and buf_valid=1; otherwise IDLE.
REQ-015 The pixel index (10 bits) shall clear on line_start and increment on each pix_strobe, saturating at MAX_PIXELS.
REQ-016 In CAPTURE, each pix_strobe with index<MAX_PIXELS shall write pix_rgb to buffer[index]; strobes at index>=MAX_PIXELS shall be dropped.
REQ-017 In CAPTURE, out_rgb shall equal pix_rgb delayed by exactly 2 cycles, and out_strobe shall equal pix_strobe delayed by 2 cycles.
REQ-018 In REPLAY, each pix_strobe shall read buffer[index]; the data shall appear on out_rgb 2 cycles after the strobe, with out_strobe asserted.
REQ-019 In REPLAY, indices >= cap_count (pixels captured on the last CAPTURE line) shall output 0x000000 with out_strobe still asserted.
REQ-020 In IDLE, out_rgb shall be 0x000000 and out_strobe shall follow pix_strobe delayed by 2 cycles.
REQ-021 On the line_start that ends a CAPTURE line, cap_count shall latch the index and buf_valid shall set to 1.
REQ-022 frame_start shall clear buf_valid before the state decision in the same cycle, so the first line of a frame never replays.
REQ-023 When a line_start arrives mid-line, the line in progress shall be truncated and pipeline contents already in flight shall still drain on out_rgb.
REQ-024 A line_start and a pix_strobe in the same cycle shall treat that pixel as index 0 of the new line.
REQ-025 replaying shall be high exactly while the state is REPLAY.

Reset
REQ-026 While reset or vdp_super=0: state=IDLE, index=0, cap_count=0, buf_valid=0, out_rgb=0, out_strobe=0, replaying=0 and pipeline registers=0; buffer contents need not be cleared.
REQ-027 Reset asserted mid-line shall take effect on the same edge; after release, output shall stay black until the next CAPTURE line.

Configuration
REQ-028 Macro VDP_SUPER_SCANLINE_DIM_EN: when defined, REPLAY pixels shall be output with each 8-bit channel halved (logical shift right by 1); when undefined, REPLAY pixels shall be output unmodified.
REQ-029 The macro shall not change latency, the CAPTURE path, the IDLE path or the interface.

Structure
REQ-030 Package vdp_super_pkg shall hold the replay_state_t enum, the MAX_PIXELS default (720) and the rgb24_t typedef.
REQ-031 The buffer shall be a sub-module vdp_line_ram: single-clock simple dual-port, MAX_PIXELS x 24, 1-cycle registered read.

Verification
REQ-032 CAPTURE line of 720 strobes with rgb=index, then REPLAY line -> replay out_rgb equals the captured values in order, each 2 cycles after its strobe.
REQ-033 CAPTURE line of 500 pixels, then REPLAY of 720 strobes -> pixels 500..719 output 0x000000 with out_strobe=1.
REQ-034 frame_start with active_line=0 -> IDLE state, black output, replaying=0.
REQ-035 CAPTURE 0xFF8040 with DIM_EN defined -> REPLAY outputs 0x7F4020; with DIM_EN undefined -> 0xFF8040.
REQ-036 Reset pulse at pixel 300 of a REPLAY line -> outputs 0 on the next edge; next non-active line stays IDLE.
REQ-037 800 strobes on a CAPTURE line -> cap_count=720, no buffer write past index 719.

Source files
------------

// File: rtl/vdp_super_pkg.sv
// Shared types and constants for the super-mode scanline replay block.
package vdp_super_pkg;

    // Default line buffer depth in pixels
    localparam int VDP_MAX_PIXELS = 720;

    // {red, green, blue}, 8 bits per channel
    typedef logic [23:0] rgb24_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_REPLAY  = 2'd2
    } replay_state_t;

    // Halve each 8-bit channel independently (logical shift right by one)
    function automatic rgb24_t rgb_dim(input rgb24_t c);
        return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
    endfunction

endpackage

// File: rtl/vdp_super_line_replay_if.sv
// Pixel/control bundle between the super-res fetcher, the replay block and the encoder.
// Handshake: pix_strobe qualifies pix_rgb in the same cycle, out_strobe qualifies
// out_rgb in the same cycle; there is no backpressure (no ready) on either side.
// dbg_* signals expose internal state for observation only.
interface vdp_super_line_replay_if;
    import vdp_super_pkg::*;

    logic          vdp_super;
    logic          line_start;
    logic          frame_start;
    logic          active_line;
    logic          pix_strobe;
    rgb24_t        pix_rgb;
    rgb24_t        out_rgb;
    logic          out_strobe;
    logic          replaying;
    replay_state_t dbg_state;
    logic [9:0]    dbg_cap_count;
    logic          dbg_buf_valid;

    modport master (
        output vdp_super, line_start, frame_start, active_line, pix_strobe, pix_rgb,
        input  out_rgb, out_strobe, replaying, dbg_state, dbg_cap_count, dbg_buf_valid
    );

    modport slave (
        input  vdp_super, line_start, frame_start, active_line, pix_strobe, pix_rgb,
        output out_rgb, out_strobe, replaying, dbg_state, dbg_cap_count, dbg_buf_valid
    );

endinterface

// File: rtl/vdp_line_ram.sv
// Single-clock simple dual-port line buffer with one-cycle registered read.
module vdp_line_ram
    import vdp_super_pkg::*;
#(
    parameter int DEPTH = VDP_MAX_PIXELS,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  rgb24_t        i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output rgb24_t        o_rdata
);

    rgb24_t r_mem [DEPTH];
    rgb24_t r_rdata;

    // Write port and registered read port; contents are never cleared
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vdp_super_line_replay.sv
// Super-mode scanline replay: captures fetched lines into a buffer and repeats
// them on non-active lines, with a fixed two-cycle pixel latency in every mode.
// Optional build macro VDP_SUPER_SCANLINE_DIM_EN halves each channel of replayed pixels.
module vdp_super_line_replay
    import vdp_super_pkg::*;
#(
    parameter int MAX_PIXELS = VDP_MAX_PIXELS
) (
    input  logic                     clk,
    input  logic                     reset,
    vdp_super_line_replay_if.slave   bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_REPLAY  = 2'd2;
    localparam logic [9:0] W_MAX     = 10'(MAX_PIXELS);

    logic [1:0] r_state;
    logic [9:0] r_idx;
    logic [9:0] r_cap_count;
    logic       r_buf_valid;
    logic       r_s1_stb;
    logic       r_s1_cap;
    logic       r_s1_rep;
    rgb24_t     r_s1_rgb;
    logic       r_out_stb;
    rgb24_t     r_out_rgb;

    logic [1:0] w_state_nxt;
    logic [9:0] w_cap_nxt;
    logic       w_bv_nxt;
    logic [9:0] w_idx_cur;
    logic [9:0] w_idx_nxt;
    logic       w_in_range;
    logic       w_we;
    logic       w_re;
    logic       w_rep_hit;
    rgb24_t     w_rdata;
    rgb24_t     w_rep_rgb;

    // Line-boundary decision: close out a capture, apply frame clear, pick next state
    always_comb begin
        w_state_nxt = r_state;
        w_cap_nxt   = r_cap_count;
        w_bv_nxt    = r_buf_valid;
        if (bus.line_start) begin
            if (r_state == S_CAPTURE) begin
                w_bv_nxt  = 1'b1;
                w_cap_nxt = r_idx;
            end
            if (bus.frame_start) begin
                w_bv_nxt = 1'b0;
            end
            if (bus.active_line) begin
                w_state_nxt = S_CAPTURE;
            end else if (w_bv_nxt) begin
                w_state_nxt = S_REPLAY;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    // A strobe coinciding with line_start is pixel 0 of the new line
    assign w_idx_cur  = bus.line_start ? 10'd0 : r_idx;
    assign w_in_range = (w_idx_cur < W_MAX);
    assign w_idx_nxt  = bus.line_start ? {9'd0, bus.pix_strobe} :
                        ((bus.pix_strobe && (r_idx < W_MAX)) ? r_idx + 10'd1 : r_idx);

    assign w_we      = bus.vdp_super && bus.pix_strobe && (w_state_nxt == S_CAPTURE) && w_in_range;
    assign w_re      = bus.vdp_super && bus.pix_strobe && (w_state_nxt == S_REPLAY) && w_in_range;
    assign w_rep_hit = w_re && (w_idx_cur < w_cap_nxt);

    vdp_line_ram #(
        .DEPTH (MAX_PIXELS),
        .AW    (10)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_idx_cur),
        .i_wdata (bus.pix_rgb),
        .i_re    (w_re),
        .i_raddr (w_idx_cur),
        .o_rdata (w_rdata)
    );

`ifdef VDP_SUPER_SCANLINE_DIM_EN
    assign w_rep_rgb = rgb_dim(w_rdata);
`else
    assign w_rep_rgb = w_rdata;
`endif

    // Control state: state, pixel index, captured length and buffer-valid flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= 10'd0;
            r_cap_count <= 10'd0;
            r_buf_valid <= 1'b0;
        end else if (!bus.vdp_super) begin
            r_state     <= S_IDLE;
            r_idx       <= 10'd0;
            r_cap_count <= 10'd0;
            r_buf_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_cap_count <= w_cap_nxt;
            r_buf_valid <= w_bv_nxt;
        end
    end

    // Two-stage pixel pipeline; each pixel carries its own mode so a truncated line still drains
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_stb  <= 1'b0;
            r_s1_cap  <= 1'b0;
            r_s1_rep  <= 1'b0;
            r_s1_rgb  <= '0;
            r_out_stb <= 1'b0;
            r_out_rgb <= '0;
        end else if (!bus.vdp_super) begin
            r_s1_stb  <= 1'b0;
            r_s1_cap  <= 1'b0;
            r_s1_rep  <= 1'b0;
            r_s1_rgb  <= '0;
            r_out_stb <= 1'b0;
            r_out_rgb <= '0;
        end else begin
            r_s1_stb  <= bus.pix_strobe;
            r_s1_cap  <= (w_state_nxt == S_CAPTURE);
            r_s1_rep  <= w_rep_hit;
            r_s1_rgb  <= bus.pix_rgb;
            r_out_stb <= r_s1_stb;
            r_out_rgb <= r_s1_cap ? r_s1_rgb : (r_s1_rep ? w_rep_rgb : 24'h000000);
        end
    end

    assign bus.out_rgb       = r_out_rgb;
    assign bus.out_strobe    = r_out_stb;
    assign bus.replaying     = (r_state == S_REPLAY);
    assign bus.dbg_state     = replay_state_t'(r_state);
    assign bus.dbg_cap_count = r_cap_count;
    assign bus.dbg_buf_valid = r_buf_valid;

endmodule
